// File: rtl/sync_counter_pkg.sv
// Shared types for the synchronous down counter family.
// Holds the default width, the count type and the one-shot FSM state encoding.
// No logic lives here.
package sync_counter_pkg;

  localparam int DEF_WIDTH = 4;

  typedef logic [DEF_WIDTH-1:0] cnt_t;

  typedef enum logic {
    OS_RUN  = 1'b0,
    OS_DONE = 1'b1
  } os_state_t;

endpackage

// File: rtl/t_ff_ar.sv
// Single T flip-flop with asynchronous active-high reset to a supplied value.
// Latency: q updates on the clock edge after t/ld are sampled.
// Synchronous load (ld/d) has priority over toggle, so parallel load stays inside the chain.
module t_ff_ar
  import sync_counter_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rst_val,
  input  logic i_t,
  input  logic i_ld,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  // Reset forces the programmed value; load beats toggle; otherwise hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= i_rst_val;
    end else if (i_ld) begin
      r_q <= i_d;
    end else if (i_t) begin
      r_q <= ~r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sync_down_counter.sv
// Synchronous binary down counter built from a chain of T flip-flops with a borrow output.
// Latency: Q one edge after en/load; zero and borrow follow Q combinationally.
// Optional one-shot mode under macro SYNC_DOWN_CNT_ONESHOT_EN: stops at 0 and raises done.
module sync_down_counter
  import sync_counter_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             zero,
  output logic             borrow
`ifdef SYNC_DOWN_CNT_ONESHOT_EN
  ,
  output logic             done
`endif
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_t;
  logic             w_zero;
  logic             w_cnt_en;
  logic             w_borrow;

  assign w_zero = (w_q == '0);

`ifdef SYNC_DOWN_CNT_ONESHOT_EN
  os_state_t r_state;
  os_state_t w_state_nxt;

  // One-shot state register; reset lands in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= OS_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and count gating: in RUN the terminal decrement is suppressed so Q sticks at 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_en    = 1'b0;
    w_borrow    = 1'b0;
    case (r_state)
      OS_RUN: begin
        w_cnt_en = en & ~w_zero;
        w_borrow = en & w_zero;
        if (!load && en && w_zero) begin
          w_state_nxt = OS_DONE;
        end
      end
      OS_DONE: begin
        if (load) begin
          w_state_nxt = OS_RUN;
        end
      end
      default: w_state_nxt = OS_RUN;
    endcase
  end

  assign done = (r_state == OS_DONE);
`else
  assign w_cnt_en = en;
  assign w_borrow = en & w_zero;
`endif

  // Borrow chain: bit i toggles when counting and every lower bit is already 0.
  assign w_t[0] = w_cnt_en;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign w_t[gi] = w_t[gi-1] & ~w_q[gi-1];
    end

    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      t_ff_ar u_tff (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_rst_val (RST_VAL[gi]),
        .i_t       (w_t[gi]),
        .i_ld      (load),
        .i_d       (load_val[gi]),
        .o_q       (w_q[gi])
      );
    end
  endgenerate

  assign Q      = w_q;
  assign zero   = w_zero;
  assign borrow = w_borrow;

endmodule

// File: tb/tb_sync_down_counter.sv
// Scoreboard bench for sync_down_counter: driver pushes expected outputs, negedge monitor compares.
module tb_sync_down_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       zero;
  logic       borrow;
  logic       done_w;

  always #5 clk = ~clk;

  sync_down_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .Q        (q),
    .zero     (zero),
    .borrow   (borrow)
`ifdef SYNC_DOWN_CNT_ONESHOT_EN
    ,
    .done     (done_w)
`endif
  );

`ifndef SYNC_DOWN_CNT_ONESHOT_EN
  assign done_w = 1'b0;

  // Cascade pair: low stage borrow drives high stage enable.
  logic       c_en;
  logic       c_load;
  logic [3:0] c_lv;
  logic [3:0] c_lo_q;
  logic [3:0] c_hi_q;
  logic       c_lo_z;
  logic       c_hi_z;
  logic       c_lo_b;
  logic       c_hi_b;

  sync_down_counter #(.WIDTH(4)) u_lo (
    .clk(clk), .reset(reset), .en(c_en), .load(c_load), .load_val(c_lv),
    .Q(c_lo_q), .zero(c_lo_z), .borrow(c_lo_b)
  );
  sync_down_counter #(.WIDTH(4)) u_hi (
    .clk(clk), .reset(reset), .en(c_lo_b), .load(c_load), .load_val(c_lv),
    .Q(c_hi_q), .zero(c_hi_z), .borrow(c_hi_b)
  );
`endif

  typedef struct packed {
    logic [3:0] q;
    logic       z;
    logic       b;
    logic       d;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    checks   = 0;
  int    failures = 0;

  // Reference model state
  logic [3:0] mq;
  logic       mdone;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Called at posedge+1: apply inputs, push the expected view of this cycle, step the model.
  task automatic drive(input logic e, input logic l, input logic [3:0] lv, input string nm);
    exp_t it;
    en       = e;
    load     = l;
    load_val = lv;
    it.q = mq;
    it.z = (mq == 4'h0);
    it.b = e && (mq == 4'h0) && !mdone;
    it.d = mdone;
    exp_q.push_back(it);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    if (l) begin
      mq    = lv;
      mdone = 1'b0;
    end else if (e && !mdone) begin
`ifdef SYNC_DOWN_CNT_ONESHOT_EN
      if (mq == 4'h0) mdone = 1'b1;
      else            mq    = mq - 4'h1;
`else
      mq = mq - 4'h1;
`endif
    end
  endtask

  // Monitor: compare outputs against the oldest expected entry, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      chk({n, "_q"}, {28'h0, q}, {28'h0, e.q});
      chk({n, "_zero"}, {31'h0, zero}, {31'h0, e.z});
      chk({n, "_borrow"}, {31'h0, borrow}, {31'h0, e.b});
`ifdef SYNC_DOWN_CNT_ONESHOT_EN
      chk({n, "_done"}, {31'h0, done_w}, {31'h0, e.d});
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    load     = 1'b0;
    load_val = 4'h0;
    mq       = 4'hF;
    mdone    = 1'b0;
`ifndef SYNC_DOWN_CNT_ONESHOT_EN
    c_en   = 1'b0;
    c_load = 1'b0;
    c_lv   = 4'h0;
`endif
    #3;
    chk("por_q", {28'h0, q}, 32'hF);
    chk("por_zero", {31'h0, zero}, 32'h0);
    chk("por_borrow", {31'h0, borrow}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Load 7, then assert reset mid-cycle with enable active
    drive(1'b0, 1'b1, 4'h7, "ld7");
    chk("ld7_now", {28'h0, q}, 32'h7);
    load = 1'b0;
    en   = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_q", {28'h0, q}, 32'hF);
    chk("async_rst_zero", {31'h0, zero}, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_en", {28'h0, q}, 32'hF);
    @(negedge clk);
    en    = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    mq    = 4'hF;
    mdone = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'h0, "hold");

    // Count through wrap: F..0 then F, E
    for (int i = 0; i < 17; i++) drive(1'b1, 1'b0, 4'h0, "count");
`ifndef SYNC_DOWN_CNT_ONESHOT_EN
    chk("wrap_end", {28'h0, q}, 32'hE);
`endif

    // Load has priority over enable
    drive(1'b0, 1'b1, 4'h9, "ld9");
    drive(1'b1, 1'b1, 4'h3, "ld_prio");
    chk("ld_prio_now", {28'h0, q}, 32'h3);
    drive(1'b1, 1'b0, 4'h0, "after_ld");
    chk("after_ld_now", {28'h0, q}, 32'h2);

    // Random enable gating from 0xA
    drive(1'b0, 1'b1, 4'hA, "ldA");
    for (int i = 0; i < 200; i++) drive(1'($urandom_range(1, 0)), 1'b0, 4'h0, "rand_en");
    drive(1'b0, 1'b0, 4'h0, "rand_end");

`ifdef SYNC_DOWN_CNT_ONESHOT_EN
    // One-shot: 2,1,0,0,0 with done after the terminal edge, single borrow
    drive(1'b0, 1'b1, 4'h2, "os_ld2");
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 4'h0, "os_run");
    chk("os_stuck_q", {28'h0, q}, 32'h0);
    chk("os_done_hi", {31'h0, done_w}, 32'h1);
    drive(1'b1, 1'b1, 4'h5, "os_reload");
    chk("os_done_lo", {31'h0, done_w}, 32'h0);
    chk("os_reload_q", {28'h0, q}, 32'h5);
    drive(1'b1, 1'b0, 4'h0, "os_resume");
    chk("os_resume_q", {28'h0, q}, 32'h4);
`else
    // Cascade: both stages loaded with 0, then 1 edge -> FF, 16 more -> EF
    en     = 1'b0;
    c_en   = 1'b1;
    c_load = 1'b1;
    c_lv   = 4'h0;
    @(posedge clk);
    #1;
    c_load = 1'b0;
    chk("casc_ld", {24'h0, c_hi_q, c_lo_q}, 32'h00);
    @(posedge clk);
    #1;
    chk("casc_ff", {24'h0, c_hi_q, c_lo_q}, 32'hFF);
    repeat (16) @(posedge clk);
    #1;
    chk("casc_ef", {24'h0, c_hi_q, c_lo_q}, 32'hEF);
`endif

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
